// File: rtl/pixel_block_loader.sv
// Assembles a BLK_DIM x BLK_DIM block of raster-order pixels into one wide output word.
// Optional BLK_LOADER_DBUF_EN: a separate fill buffer so the next block fills while one is held.
module pixel_block_loader #(
  parameter int BLK_DIM = 15,
  parameter int PIX_W   = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [PIX_W-1:0]                 pix_in,
  input  logic                             pix_valid,
  input  logic                             pix_sof,
  output logic                             pix_ready,
  output logic [BLK_DIM*BLK_DIM*PIX_W-1:0] integer_array,
  output logic                             blk_valid,
  input  logic                             blk_ready,
  output logic                             sof_err
);
  localparam int TOT_W = BLK_DIM * BLK_DIM * PIX_W;
  localparam int CNT_W = (BLK_DIM > 1) ? $clog2(BLK_DIM) : 1;
  localparam int OFF_W = $clog2(TOT_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLK_DIM - 1);

  logic [CNT_W-1:0] col, row, col_nxt, row_nxt;
  logic             beat, at_origin, restart, done;
  logic [OFF_W-1:0] wr_off;

  assign beat      = pix_valid && pix_ready;
  assign at_origin = (row == '0) && (col == '0);
  assign restart   = beat && pix_sof && !at_origin;
  assign done      = beat && !restart && (row == LAST_IDX) && (col == LAST_IDX);

  // a premature start-of-frame pixel lands at (0,0) regardless of the counters
  assign wr_off = restart ? '0
                : OFF_W'(row) * OFF_W'(BLK_DIM * PIX_W) + OFF_W'(col) * OFF_W'(PIX_W);

  always_comb begin
    col_nxt = col;
    row_nxt = row;
    if (restart) begin
      col_nxt = CNT_W'(1);
      row_nxt = '0;
    end else if (beat) begin
      if (col == LAST_IDX) begin
        col_nxt = '0;
        row_nxt = (row == LAST_IDX) ? '0 : row + 1'b1;
      end else begin
        col_nxt = col + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col     <= '0;
      row     <= '0;
      sof_err <= 1'b0;
    end else begin
      col     <= col_nxt;
      row     <= row_nxt;
      sof_err <= restart;
    end
  end

`ifdef BLK_LOADER_DBUF_EN
  logic [TOT_W-1:0] fill_buf;
  logic             fb_full, load;

  assign pix_ready = !fb_full;
  assign load      = fb_full && (!blk_valid || blk_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill_buf      <= '0;
      fb_full       <= 1'b0;
      integer_array <= '0;
      blk_valid     <= 1'b0;
    end else begin
      if (beat) fill_buf[wr_off +: PIX_W] <= pix_in;
      // done needs pix_ready, load needs fb_full: never both in one cycle
      if (done)      fb_full <= 1'b1;
      else if (load) fb_full <= 1'b0;
      if (load) begin
        integer_array <= fill_buf;
        blk_valid     <= 1'b1;
      end else if (blk_ready) begin
        blk_valid <= 1'b0;
      end
    end
  end
`else
  assign pix_ready = !blk_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      integer_array <= '0;
      blk_valid     <= 1'b0;
    end else begin
      if (beat) integer_array[wr_off +: PIX_W] <= pix_in;
      if (done)           blk_valid <= 1'b1;
      else if (blk_ready) blk_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/pixel_block_loader.md
PIXEL_BLOCK_LOADER -- requirements
Module: pixel_block_loader

Interface
REQ-001 SHALL have parameter: BLK_DIM, 15, block edge length in integer pixels.
REQ-002 SHALL have parameter: PIX_W, 8, bits per pixel.
REQ-003 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port: pix_in  input  PIX_W  incoming integer pixel, raster order (row-major, column 0 first).
REQ-006 SHALL have port: pix_valid  input  1  pix_in valid.
REQ-007 SHALL have port: pix_sof  input  1  marks first pixel of a block; qualified by pix_valid.
REQ-008 SHALL have port: pix_ready  output  1  loader accepts a pixel this cycle.
REQ-009 SHALL have port: integer_array  output  BLK_DIM*BLK_DIM*PIX_W (1800)  assembled block for the input array mux.
REQ-010 SHALL have port: blk_valid  output  1  integer_array holds a complete block.
REQ-011 SHALL have port: blk_ready  input  1  consumer takes the block this cycle.
REQ-012 SHALL have port: sof_err  output  1  one-cycle pulse on premature pix_sof.

Function
REQ-013 SHALL accept a pixel only on a cycle with pix_valid=1 and pix_ready=1 (a "beat").
REQ-014 SHALL keep column counter c (0..BLK_DIM-1) and row counter r (0..BLK_DIM-1); each beat writes pixel at (r,c), then c increments, wrapping to 0 with r+1.
REQ-015 SHALL place pixel (r,c) at integer_array bits [PIX_W*c + PIX_W*BLK_DIM*r +: PIX_W].
REQ-016 SHALL treat the beat at (BLK_DIM-1,BLK_DIM-1) as block completion; counters return to (0,0).
REQ-017 SHALL, on a beat with pix_sof=1 while (r,c)!=(0,0), discard the partial block, write the pixel at (0,0), set counters to (0,1), and pulse sof_err for exactly the next cycle.
REQ-018 SHALL accept pix_sof=0 at (0,0) as a normal first pixel (pix_sof optional at block start); pix_sof=1 at (0,0) is not an error.
REQ-019 SHALL clear blk_valid on the rising edge where blk_valid=1 and blk_ready=1, unless a new block is transferred the same edge (REQ-024).
REQ-020 SHALL hold integer_array and blk_valid stable while blk_valid=1 and blk_ready=0.
REQ-021 SHALL ignore blk_ready while blk_valid=0, and ignore pix_in/pix_sof while pix_valid=0 or pix_ready=0.
REQ-022 SHALL derive pix_ready combinationally from registered state only (no combinational path from pix_valid or blk_ready).

Reset
REQ-023 SHALL, while reset=0, force integer_array=0, blk_valid=0, sof_err=0, counters (0,0), fill-buffer-full flag 0, pix_ready=1; reset asserted mid-block discards the partial block and any held block.

Configuration
REQ-024 SHALL support macro BLK_LOADER_DBUF_EN. Defined: separate fill buffer plus integer_array output register; completion sets fb_full (next edge); pix_ready=!fb_full; when fb_full=1 and (blk_valid=0 or blk_ready=1), copy fill buffer to integer_array, set blk_valid=1, clear fb_full on the same edge; latency last beat -> blk_valid = 2 cycles; back-to-back blocks stream with blk_ready held 1.
REQ-025 SHALL, without BLK_LOADER_DBUF_EN, write pixels directly into integer_array; pix_ready=!blk_valid; completion sets blk_valid=1 on the next edge (latency 1 cycle); pixels cannot be accepted until the block is taken; integer_array contents are meaningful only while blk_valid=1.

Verification
REQ-026 SHALL cover: 225 beats, pixel(r,c)=15r+c, pix_sof on first, blk_ready=1 -> integer_array[7:0]=00, [15:8]=01, [127:120]=0F, [1799:1792]=E0; blk_valid latency 1 (no macro) / 2 (macro).
REQ-027 SHALL cover: block completed with blk_ready=0 for 20 cycles -> blk_valid and integer_array stable; no macro: pix_ready=0 throughout; macro: second block's 225 beats accepted, then pix_ready=0 until blk_ready.
REQ-028 SHALL cover: pix_sof=1 on 100th beat (value AA) -> sof_err=1 one cycle; following 224 beats complete block with integer_array[7:0]=AA.
REQ-029 SHALL cover: reset=0 asynchronously after 50 beats -> outputs immediately 0, pix_ready=1; next 225 beats form a correct block.
REQ-030 SHALL cover: macro defined, two blocks streamed with random pix_valid gaps and blk_ready=1 -> two blk_valid pulses, contents match, no beat lost.
REQ-031 SHALL cover: blk_ready=1 with blk_valid=0 and pix_valid=1 with pix_sof=1 at (0,0) -> no state change besides normal write, sof_err stays 0.
